// File: rtl/io_channel_sequencer_if.sv
// ============================================================================
// Module   : io_channel_sequencer_if
// Purpose  : Harness/core-facing signal bundle for io_channel_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface io_channel_sequencer_if #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 3,
  parameter int NOut               = 9
);
  localparam int c_PW = $clog2(NIn + 1);
  localparam int c_QW = $clog2(NOut + 1);

  logic                          start;
  logic [MemoryElementWidth-1:0] loadData;
  logic                          loadValid;
  logic                          loadLast;
  logic                          loadReady;
  logic                          coreRun;
  logic                          coreFinished;
  logic [c_PW-1:0]               inSize;
  logic [MemoryElementWidth-1:0] inData;
  logic                          inReq;
  logic                          outReq;
  logic [MemoryElementWidth-1:0] outData;
  logic [MemoryElementWidth-1:0] drainData;
  logic                          drainValid;
  logic                          drainReady;
  logic                          busy;
  logic                          done;
  logic                          timeout;
  logic                          overflow;
  logic [c_QW-1:0]               outCount;

  modport master (
    output start, loadData, loadValid, loadLast, coreFinished,
           inReq, outReq, outData, drainReady,
    input  loadReady, coreRun, inSize, inData, drainData, drainValid,
           busy, done, timeout, overflow, outCount
  );

  modport slave (
    input  start, loadData, loadValid, loadLast, coreFinished,
           inReq, outReq, outData, drainReady,
    output loadReady, coreRun, inSize, inData, drainData, drainValid,
           busy, done, timeout, overflow, outCount
  );
endinterface

`default_nettype wire

// File: rtl/io_channel_sequencer.sv
// ============================================================================
// Module   : io_channel_sequencer
// Purpose  : Loads the in channel, runs the core, serves in/out, drains out.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module io_channel_sequencer #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 3,
  parameter int NOut               = 9,
  parameter int MaxSteps           = 32
) (
  input logic                   clock,
  input logic                   reset,
  io_channel_sequencer_if.slave bus
);
  localparam int c_PW = $clog2(NIn + 1);
  localparam int c_QW = $clog2(NOut + 1);
  localparam int c_SW = $clog2(MaxSteps + 1);
  localparam logic [c_PW-1:0] c_NIN       = c_PW'(NIn);
  localparam logic [c_QW-1:0] c_NOUT      = c_QW'(NOut);
  localparam logic [c_QW-1:0] c_NOUT_LAST = c_QW'(NOut - 1);
  localparam logic [c_QW-1:0] c_ONE       = c_QW'(1);
  localparam logic [c_SW-1:0] c_STEP_LAST = c_SW'(MaxSteps - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                        r_state;
  logic [MemoryElementWidth-1:0] r_inMem  [NIn];
  logic [MemoryElementWidth-1:0] r_outMem [NOut];
  logic [c_PW-1:0]               r_inCount, r_inPos;
  logic [c_QW-1:0]               r_outPos, r_outCount, r_rdPtr, r_remaining;
  logic [c_SW-1:0]               r_steps;
  logic                          r_timeout, r_overflow, r_drainValid;
  logic                          r_loadReady, r_coreRun, r_busy, r_done;

  logic [c_PW-1:0] w_inSize, w_inCountInc;
  logic            w_loadFire, w_inPop, w_outWrite, w_overflowNext;
  logic [c_QW-1:0] w_outPosNext, w_outCountNext, w_rdNext;

  assign w_inSize     = r_inCount - r_inPos;
  assign w_inCountInc = r_inCount + 1'b1;
  assign w_loadFire   = (r_state == S_LOAD) && bus.loadValid;
  assign w_inPop      = (r_state == S_RUN) && bus.inReq && (w_inSize != '0);
  assign w_outWrite   = (r_state == S_RUN) && bus.outReq;

  // Post-write out-channel view, also used to seed the drain on the RUN exit cycle.
  assign w_outPosNext   = !w_outWrite ? r_outPos :
                          (r_outPos == c_NOUT_LAST) ? '0 : r_outPos + 1'b1;
  assign w_outCountNext = (w_outWrite && (r_outCount != c_NOUT)) ? r_outCount + 1'b1 : r_outCount;
  assign w_overflowNext = r_overflow | (w_outWrite && (r_outCount == c_NOUT));
  assign w_rdNext       = (r_rdPtr == c_NOUT_LAST) ? '0 : r_rdPtr + 1'b1;

  always_ff @(posedge clock) begin
    if (w_loadFire) r_inMem[r_inCount]  <= bus.loadData;
    if (w_outWrite) r_outMem[r_outPos]  <= bus.outData;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_inCount    <= '0;
      r_inPos      <= '0;
      r_outPos     <= '0;
      r_outCount   <= '0;
      r_rdPtr      <= '0;
      r_remaining  <= '0;
      r_steps      <= '0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
      r_drainValid <= 1'b0;
      r_loadReady  <= 1'b0;
      r_coreRun    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state     <= S_LOAD;
            r_inCount   <= '0;
            r_inPos     <= '0;
            r_outPos    <= '0;
            r_outCount  <= '0;
            r_steps     <= '0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_loadReady <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.loadValid) begin
            r_inCount <= w_inCountInc;
            if ((w_inCountInc == c_NIN) || bus.loadLast) begin
              r_state     <= S_RUN;
              r_loadReady <= 1'b0;
              r_coreRun   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_steps    <= r_steps + 1'b1;
          r_outPos   <= w_outPosNext;
          r_outCount <= w_outCountNext;
          r_overflow <= w_overflowNext;
          if (w_inPop) r_inPos <= r_inPos + 1'b1;
          // coreFinished takes priority over the watchdog on the same cycle.
          if (bus.coreFinished || (r_steps == c_STEP_LAST)) begin
            r_timeout    <= !bus.coreFinished;
            r_state      <= S_DRAIN;
            r_coreRun    <= 1'b0;
            r_rdPtr      <= w_overflowNext ? w_outPosNext : '0;
            r_remaining  <= w_outCountNext;
            r_drainValid <= (w_outCountNext != '0);
          end
        end
        S_DRAIN: begin
          if (!r_drainValid) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (bus.drainReady) begin
            r_rdPtr     <= w_rdNext;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == c_ONE) begin
              r_drainValid <= 1'b0;
              r_state      <= S_DONE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.loadReady  = r_loadReady;
  assign bus.coreRun    = r_coreRun;
  assign bus.inSize     = w_inSize;
  assign bus.inData     = (r_inPos < c_NIN) ? r_inMem[r_inPos] : '0;
  assign bus.drainData  = r_outMem[r_rdPtr];
  assign bus.drainValid = r_drainValid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.timeout    = r_timeout;
  assign bus.overflow   = r_overflow;
  assign bus.outCount   = r_outCount;
endmodule

`default_nettype wire

// File: tb/tb_io_channel_sequencer.sv
// ============================================================================
// Module   : tb_io_channel_sequencer
// Purpose  : Directed self-checking bench for io_channel_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_io_channel_sequencer;
  localparam int c_W    = 12;
  localparam int c_NIN  = 3;
  localparam int c_NOUT = 9;
  localparam int c_MAXS = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  io_channel_sequencer_if #(.MemoryElementWidth(c_W), .NIn(c_NIN), .NOut(c_NOUT)) bus ();

  io_channel_sequencer #(
    .MemoryElementWidth(c_W), .NIn(c_NIN), .NOut(c_NOUT), .MaxSteps(c_MAXS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int               nCompared   = 0;
  int               nMismatched = 0;
  logic [c_W-1:0]   expWords[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    bus.start        = 1'b0;
    bus.loadData     = '0;
    bus.loadValid    = 1'b0;
    bus.loadLast     = 1'b0;
    bus.coreFinished = 1'b0;
    bus.inReq        = 1'b0;
    bus.outReq       = 1'b0;
    bus.outData      = '0;
    bus.drainReady   = 1'b0;
  endtask

  task automatic startRun();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("loadReady_after_start", bus.loadReady, 1);
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic loadWord(input logic [c_W-1:0] d, input logic last);
    bus.loadData  = d;
    bus.loadValid = 1'b1;
    bus.loadLast  = last;
    tick();
    bus.loadValid = 1'b0;
    bus.loadLast  = 1'b0;
  endtask

  task automatic core(input logic ir, input logic orq, input logic [c_W-1:0] d, input logic fin);
    bus.inReq        = ir;
    bus.outReq       = orq;
    bus.outData      = d;
    bus.coreFinished = fin;
    tick();
    bus.inReq        = 1'b0;
    bus.outReq       = 1'b0;
    bus.coreFinished = 1'b0;
  endtask

  task automatic drainAll(input logic toggle);
    for (int i = 0; i < expWords.size(); i++) begin
      int waitCyc = 0;
      while (bus.drainValid !== 1'b1 && waitCyc < 8) begin
        tick();
        waitCyc++;
      end
      check("drainValid", bus.drainValid, 1);
      check("drainData", bus.drainData, expWords[i]);
      if (toggle) begin
        bus.drainReady = 1'b0;
        tick();
        check("drainHoldData", bus.drainData, expWords[i]);
        check("drainHoldValid", bus.drainValid, 1);
      end
      bus.drainReady = 1'b1;
      tick();
      bus.drainReady = 1'b0;
    end
  endtask

  task automatic runScenario1();
    startRun();
    loadWord(12'd33, 1'b0);
    loadWord(12'd22, 1'b0);
    loadWord(12'd11, 1'b0);
    check("s1_coreRun", bus.coreRun, 1);
    check("s1_loadReady", bus.loadReady, 0);
    check("s1_inSize3", bus.inSize, 3);
    core(1'b0, 1'b1, 12'd1, 1'b0);
    core(1'b0, 1'b1, 12'd2, 1'b0);
    core(1'b0, 1'b1, 12'd3, 1'b0);
    check("s1_inSize_a", bus.inSize, 3);
    core(1'b0, 1'b1, 12'd3, 1'b0);
    check("s1_inData_a", bus.inData, 33);
    core(1'b1, 1'b1, 12'd33, 1'b0);
    check("s1_inSize_b", bus.inSize, 2);
    core(1'b0, 1'b1, 12'd2, 1'b0);
    check("s1_inData_b", bus.inData, 22);
    core(1'b1, 1'b1, 12'd22, 1'b0);
    check("s1_inSize_c", bus.inSize, 1);
    core(1'b0, 1'b1, 12'd1, 1'b0);
    check("s1_inData_c", bus.inData, 11);
    core(1'b1, 1'b1, 12'd11, 1'b0);
    check("s1_inSize_0", bus.inSize, 0);
    core(1'b0, 1'b0, 12'd0, 1'b1);
    check("s1_coreRun_off", bus.coreRun, 0);
    check("s1_outCount", bus.outCount, 9);
    check("s1_overflow", bus.overflow, 0);
    expWords = '{12'd1, 12'd2, 12'd3, 12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11};
    drainAll(1'b0);
    check("s1_done", bus.done, 1);
    check("s1_busy", bus.busy, 0);
    check("s1_timeout", bus.timeout, 0);
    check("s1_drainValid_end", bus.drainValid, 0);
  endtask

  initial begin
    clearInputs();
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_loadReady", bus.loadReady, 0);
    check("rst_coreRun", bus.coreRun, 0);
    check("rst_drainValid", bus.drainValid, 0);
    check("rst_outCount", bus.outCount, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_overflow", bus.overflow, 0);
    reset = 1'b1;
    tick();
    check("idle_busy", bus.busy, 0);

    // Scenario 1: full load, interleaved pops and writes
    runScenario1();

    // Scenario 2: single word with loadLast, pop on empty
    startRun();
    loadWord(12'd5, 1'b1);
    check("s2_coreRun", bus.coreRun, 1);
    check("s2_inSize1", bus.inSize, 1);
    check("s2_inData", bus.inData, 5);
    core(1'b1, 1'b0, 12'd0, 1'b0);
    check("s2_inSize0", bus.inSize, 0);
    core(1'b1, 1'b0, 12'd0, 1'b0);
    check("s2_inSize_stay", bus.inSize, 0);
    check("s2_inPos_stay", dut.r_inPos, 1);
    core(1'b0, 1'b0, 12'd0, 1'b1);
    check("s2_noDrainValid", bus.drainValid, 0);
    check("s2_outCount0", bus.outCount, 0);
    tick();
    check("s2_done", bus.done, 1);

    // Scenario 3: out channel wraps
    startRun();
    loadWord(12'd7, 1'b1);
    for (int v = 1; v <= 11; v++) core(1'b0, 1'b1, c_W'(v), 1'b0);
    core(1'b0, 1'b0, 12'd0, 1'b1);
    check("s3_overflow", bus.overflow, 1);
    check("s3_outCount", bus.outCount, 9);
    expWords = '{12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8, 12'd9, 12'd10, 12'd11};
    drainAll(1'b0);
    check("s3_done", bus.done, 1);

    // Scenario 4: watchdog, with a start pulse in RUN that must be ignored
    startRun();
    check("s4_overflow_cleared", bus.overflow, 0);
    loadWord(12'd4, 1'b1);
    core(1'b0, 1'b1, 12'hA, 1'b0);
    core(1'b0, 1'b1, 12'hB, 1'b0);
    for (int k = 0; k < 29; k++) begin
      bus.start = (k == 5);
      tick();
    end
    bus.start = 1'b0;
    check("s4_coreRun_31", bus.coreRun, 1);
    check("s4_timeout_pre", bus.timeout, 0);
    tick();
    check("s4_coreRun_32", bus.coreRun, 0);
    check("s4_timeout", bus.timeout, 1);
    expWords = '{12'hA, 12'hB};
    drainAll(1'b0);
    check("s4_done", bus.done, 1);
    check("s4_timeout_sticky", bus.timeout, 1);

    // Scenario 5: drainReady alternates 0/1
    startRun();
    check("s5_timeout_cleared", bus.timeout, 0);
    loadWord(12'd1, 1'b1);
    core(1'b0, 1'b1, 12'h111, 1'b0);
    core(1'b0, 1'b1, 12'h222, 1'b0);
    core(1'b0, 1'b1, 12'h333, 1'b0);
    core(1'b0, 1'b1, 12'h444, 1'b0);
    core(1'b0, 1'b0, 12'd0, 1'b1);
    expWords = '{12'h111, 12'h222, 12'h333, 12'h444};
    drainAll(1'b1);
    check("s5_done", bus.done, 1);
    check("s5_drainValid_end", bus.drainValid, 0);

    // Scenario 6: reset mid-drain, then clean rerun
    startRun();
    loadWord(12'd9, 1'b1);
    core(1'b0, 1'b1, 12'd5, 1'b0);
    core(1'b0, 1'b1, 12'd6, 1'b0);
    core(1'b0, 1'b0, 12'd0, 1'b1);
    check("s6_drainValid", bus.drainValid, 1);
    check("s6_drainData0", bus.drainData, 5);
    bus.drainReady = 1'b1;
    tick();
    bus.drainReady = 1'b0;
    check("s6_drainData1", bus.drainData, 6);
    reset = 1'b0;
    tick();
    check("s6_busy", bus.busy, 0);
    check("s6_drainValid_rst", bus.drainValid, 0);
    check("s6_outCount", bus.outCount, 0);
    check("s6_done", bus.done, 0);
    reset = 1'b1;
    tick();
    runScenario1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

`default_nettype wire
